pt_axi4lite_initiator: RTL and testbench

PT_AXI4LITE_INITIATOR -- requirements
Module: pt_axi4lite_initiator

---
 rtl/pt_axi4lite_initiator.sv | 165 ++++++++++++++++
 tb/tb_pt_axi4lite_initiator.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pt_axi4lite_initiator.sv
// Register-file style request port bridged onto an AXI4-Lite initiator, one access in flight.
// Latency: acceptance to o_rf_done is 3 cycles minimum with a zero-wait-state slave, unbounded otherwise.
// Backpressure: o_rf_ready is high only while idle; AXI valids are held until their handshake completes.
module pt_axi4lite_initiator #(
    parameter int  ADDR_W = 32,
    parameter int  DATA_W = 64,
    localparam int STRB_W = DATA_W / 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    // request side
    input  logic [ADDR_W-1:0] i_rf_address,
    input  logic [DATA_W-1:0] i_rf_wr_data,
    input  logic              i_rf_write,
    input  logic              i_rf_valid,
    output logic              o_rf_ready,
    // response side
    output logic [DATA_W-1:0] o_rf_rd_data,
    output logic              o_rf_error,
    output logic              o_rf_done,
    // AXI4-Lite write channels
    output logic [ADDR_W-1:0] o_awaddr,
    output logic [2:0]        o_awprot,
    output logic              o_awvalid,
    input  logic              i_awready,
    output logic [DATA_W-1:0] o_wdata,
    output logic [STRB_W-1:0] o_wstrb,
    output logic              o_wvalid,
    input  logic              i_wready,
    input  logic [1:0]        i_bresp,
    input  logic              i_bvalid,
    output logic              o_bready,
    // AXI4-Lite read channels
    output logic [ADDR_W-1:0] o_araddr,
    output logic [2:0]        o_arprot,
    output logic              o_arvalid,
    input  logic              i_arready,
    input  logic [DATA_W-1:0] i_rdata,
    input  logic [1:0]        i_rresp,
    input  logic              i_rvalid,
    output logic              o_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP
    } state_t;

    state_t            state_q;
    logic              rf_ready_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              bready_q;
    logic              arvalid_q;
    logic              rready_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              error_q;
    logic              done_q;

    // A channel counts as finished once its valid is already down or is being accepted now,
    // so both handshakes landing in the same cycle still advance the write.
    logic aw_fin;
    logic w_fin;
    assign aw_fin = ~awvalid_q | i_awready;
    assign w_fin  = ~wvalid_q  | i_wready;

    // Only the SLVERR/DECERR bit of the response codes matters for the error flag.
    logic unused_resp_lsb;
    assign unused_resp_lsb = ^{i_bresp[0], i_rresp[0]};

    // Transaction FSM; every output is a register updated here.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q    <= IDLE;
            rf_ready_q <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            bready_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            rready_q   <= 1'b0;
            rd_data_q  <= '0;
            error_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    rf_ready_q <= 1'b1;
                    if (i_rf_valid && rf_ready_q) begin
                        rf_ready_q <= 1'b0;
                        addr_q     <= i_rf_address;
                        wdata_q    <= i_rf_wr_data;
                        if (i_rf_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state_q   <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state_q   <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (awvalid_q && i_awready) awvalid_q <= 1'b0;
                    if (wvalid_q && i_wready)   wvalid_q  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        bready_q <= 1'b1;
                        state_q  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (i_bvalid) begin
                        bready_q   <= 1'b0;
                        error_q    <= i_bresp[1];
                        done_q     <= 1'b1;
                        rf_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                RD_REQ: begin
                    if (i_arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state_q   <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    if (i_rvalid) begin
                        rready_q   <= 1'b0;
                        rd_data_q  <= i_rdata;
                        error_q    <= i_rresp[1];
                        done_q     <= 1'b1;
                        rf_ready_q <= 1'b1;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_rf_ready   = rf_ready_q;
    assign o_rf_rd_data = rd_data_q;
    assign o_rf_error   = error_q;
    assign o_rf_done    = done_q;
    assign o_awaddr     = addr_q;
    assign o_awprot     = 3'b000;
    assign o_awvalid    = awvalid_q;
    assign o_wdata      = wdata_q;
    assign o_wstrb      = '1;
    assign o_wvalid     = wvalid_q;
    assign o_bready     = bready_q;
    assign o_araddr     = addr_q;
    assign o_arprot     = 3'b000;
    assign o_arvalid    = arvalid_q;
    assign o_rready     = rready_q;

endmodule

// File: tb/tb_pt_axi4lite_initiator.sv
// Bench for pt_axi4lite_initiator: directed requests against a configurable AXI4-Lite slave model.
// Expected completions and AXI addresses/data are queued at acceptance and checked by a monitor.
// Slave ready/valid delays are programmable per test to exercise stalls and channel ordering.
module tb_pt_axi4lite_initiator;
    localparam int AW = 32;
    localparam int DW = 64;

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic [AW-1:0] i_rf_address = '0;
    logic [DW-1:0] i_rf_wr_data = '0;
    logic          i_rf_write = 1'b0;
    logic          i_rf_valid = 1'b0;
    logic          o_rf_ready;
    logic [DW-1:0] o_rf_rd_data;
    logic          o_rf_error;
    logic          o_rf_done;
    logic [AW-1:0] o_awaddr;
    logic [2:0]    o_awprot;
    logic          o_awvalid;
    logic          i_awready = 1'b0;
    logic [DW-1:0] o_wdata;
    logic [7:0]    o_wstrb;
    logic          o_wvalid;
    logic          i_wready = 1'b0;
    logic [1:0]    i_bresp = '0;
    logic          i_bvalid = 1'b0;
    logic          o_bready;
    logic [AW-1:0] o_araddr;
    logic [2:0]    o_arprot;
    logic          o_arvalid;
    logic          i_arready = 1'b0;
    logic [DW-1:0] i_rdata = '0;
    logic [1:0]    i_rresp = '0;
    logic          i_rvalid = 1'b0;
    logic          o_rready;

    pt_axi4lite_initiator #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .i_rf_address(i_rf_address), .i_rf_wr_data(i_rf_wr_data), .i_rf_write(i_rf_write),
        .i_rf_valid(i_rf_valid), .o_rf_ready(o_rf_ready),
        .o_rf_rd_data(o_rf_rd_data), .o_rf_error(o_rf_error), .o_rf_done(o_rf_done),
        .o_awaddr(o_awaddr), .o_awprot(o_awprot), .o_awvalid(o_awvalid), .i_awready(i_awready),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bresp(i_bresp), .i_bvalid(i_bvalid), .o_bready(o_bready),
        .o_araddr(o_araddr), .o_arprot(o_arprot), .o_arvalid(o_arvalid), .i_arready(i_arready),
        .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready)
    );

    always #5 i_clk = ~i_clk;

    int cyc = 0;
    always @(posedge i_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard queues, filled when a request is accepted.
    typedef struct {
        logic [DW-1:0] rd;
        logic          err;
        int            lat;
        int            acc;
    } exp_t;
    exp_t          exp_q[$];
    logic [AW-1:0] exp_aw_q[$];
    logic [DW-1:0] exp_w_q[$];
    logic [AW-1:0] exp_ar_q[$];

    // Slave model configuration.
    int            aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]    bresp_cfg = 2'b00, rresp_cfg = 2'b00;
    logic [DW-1:0] rdata_cfg = '0;
    logic          stray = 1'b0;

    // Slave model: sample handshakes mid-cycle, drive next-cycle responses just after the edge.
    bit aw_got = 0, w_got = 0, r_pend = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    always begin
        @(negedge i_clk);
        if (!i_rst) begin
            aw_got = 0; w_got = 0; r_pend = 0; b_cnt = 0; r_cnt = 0;
        end else begin
            if (o_awvalid && i_awready) aw_got = 1;
            if (o_wvalid && i_wready)   w_got = 1;
            if (i_bvalid && o_bready) begin aw_got = 0; w_got = 0; b_cnt = 0; end
            if (o_arvalid && i_arready) begin r_pend = 1; r_cnt = 0; end
            if (i_rvalid && o_rready) r_pend = 0;
        end
        @(posedge i_clk);
        #1;
        if (!i_rst) begin
            i_awready = 0; i_wready = 0; i_bvalid = 0; i_arready = 0; i_rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        end else begin
            i_awready = o_awvalid && (aw_cnt >= aw_dly);
            aw_cnt    = o_awvalid ? aw_cnt + 1 : 0;
            i_wready  = o_wvalid && (w_cnt >= w_dly);
            w_cnt     = o_wvalid ? w_cnt + 1 : 0;
            i_arready = o_arvalid && (ar_cnt >= ar_dly);
            ar_cnt    = o_arvalid ? ar_cnt + 1 : 0;
            i_bvalid  = (aw_got && w_got && (b_cnt >= b_dly)) || stray;
            if (aw_got && w_got && (b_cnt < b_dly)) b_cnt++;
            i_rvalid  = (r_pend && (r_cnt >= r_dly)) || stray;
            if (r_pend && (r_cnt < r_dly)) r_cnt++;
        end
        i_bresp = bresp_cfg;
        i_rresp = rresp_cfg;
        i_rdata = rdata_cfg;
    end

    // Monitor: completions, AXI payloads, valid stability and bready ordering.
    bit            aw_pend_p = 0, w_pend_p = 0, ar_pend_p = 0;
    logic [AW-1:0] awaddr_p, araddr_p;
    logic [DW-1:0] wdata_p;
    always @(negedge i_clk) begin
        if (!i_rst) begin
            aw_pend_p = 0; w_pend_p = 0; ar_pend_p = 0;
        end else begin
            if (o_rf_done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", exp_q.size(), 1);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("done_rd_data", o_rf_rd_data, e.rd);
                    chk("done_error", o_rf_error, e.err);
                    chk("done_latency", cyc - e.acc, e.lat);
                end
            end
            if (aw_pend_p) begin
                chk("awvalid_held", o_awvalid, 1);
                chk("awaddr_stable", o_awaddr, awaddr_p);
            end
            if (w_pend_p) begin
                chk("wvalid_held", o_wvalid, 1);
                chk("wdata_stable", o_wdata, wdata_p);
            end
            if (ar_pend_p) begin
                chk("arvalid_held", o_arvalid, 1);
                chk("araddr_stable", o_araddr, araddr_p);
            end
            if (o_awvalid && i_awready) begin
                if (exp_aw_q.size() == 0) chk("unexpected_aw", exp_aw_q.size(), 1);
                else chk("awaddr", o_awaddr, exp_aw_q.pop_front());
            end
            if (o_wvalid && i_wready) begin
                if (exp_w_q.size() == 0) chk("unexpected_w", exp_w_q.size(), 1);
                else begin
                    chk("wdata", o_wdata, exp_w_q.pop_front());
                    chk("wstrb", o_wstrb, 8'hFF);
                end
            end
            if (o_arvalid && i_arready) begin
                if (exp_ar_q.size() == 0) chk("unexpected_ar", exp_ar_q.size(), 1);
                else chk("araddr", o_araddr, exp_ar_q.pop_front());
            end
            if (o_bready) chk("bready_after_aw_and_w", o_awvalid | o_wvalid, 0);
            aw_pend_p = o_awvalid && !i_awready; awaddr_p = o_awaddr;
            w_pend_p  = o_wvalid && !i_wready;   wdata_p  = o_wdata;
            ar_pend_p = o_arvalid && !i_arready; araddr_p = o_araddr;
        end
    end

    // Present a request (caller aligned just after a rising edge) and hold it until accepted.
    task automatic issue(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [DW-1:0] exp_rd, input logic exp_err, input int exp_lat,
                         output int acc);
        exp_t e;
        bit   got;
        got = 0;
        acc = -1;
        i_rf_valid = 1'b1; i_rf_write = wr; i_rf_address = addr; i_rf_wr_data = data;
        for (int k = 0; k < 50 && !got; k++) begin
            @(negedge i_clk);
            if (o_rf_ready) begin
                got = 1;
                acc = cyc;
                e.rd = exp_rd; e.err = exp_err; e.lat = exp_lat; e.acc = cyc;
                exp_q.push_back(e);
                if (wr) begin
                    exp_aw_q.push_back(addr);
                    exp_w_q.push_back(data);
                end else begin
                    exp_ar_q.push_back(addr);
                end
            end
        end
        chk("request_accepted", got, 1);
        @(posedge i_clk);
        #1;
        i_rf_valid = 1'b0;
    endtask

    // Wait (bounded) until every expected completion has been seen.
    task automatic wait_idle();
        for (int k = 0; k < 100 && exp_q.size() != 0; k++) @(negedge i_clk);
        chk("all_completions_seen", exp_q.size(), 0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        int  a1, a2, a3;
        bit  seen;
        #1 i_rst = 1'b0;
        #1;
        chk("rst_awvalid", o_awvalid, 0);
        chk("rst_wvalid", o_wvalid, 0);
        chk("rst_arvalid", o_arvalid, 0);
        chk("rst_bready", o_bready, 0);
        chk("rst_rready", o_rready, 0);
        chk("rst_done", o_rf_done, 0);
        chk("rst_error", o_rf_error, 0);
        chk("rst_rd_data", o_rf_rd_data, 0);
        chk("rst_awaddr", o_awaddr, 0);
        chk("rst_wdata", o_wdata, 0);
        chk("awprot", o_awprot, 0);
        chk("arprot", o_arprot, 0);
        chk("wstrb_const", o_wstrb, 8'hFF);
        repeat (2) @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("ready_after_reset", o_rf_ready, 1);

        // Zero-wait write: AW/W in cycle 1, B in cycle 2, done in cycle 3.
        issue(1'b1, 32'h10, 64'hDEADBEEF_CAFEF00D, 64'h0, 1'b0, 3, a1);
        chk("wr_awvalid_c1", o_awvalid, 1);
        chk("wr_awaddr_c1", o_awaddr, 32'h10);
        chk("wr_wvalid_c1", o_wvalid, 1);
        chk("busy_not_ready", o_rf_ready, 0);
        wait_idle();

        // Read with rvalid 4 cycles after AR and SLVERR response.
        r_dly = 3; rdata_cfg = 64'h1234; rresp_cfg = 2'b10;
        issue(1'b0, 32'h20, 64'h0, 64'h1234, 1'b1, 6, a1);
        wait_idle();

        // W accepted 3 cycles before AW; read data must survive the write.
        r_dly = 0; aw_dly = 3; bresp_cfg = 2'b00;
        issue(1'b1, 32'h38, 64'h01234567_89ABCDEF, 64'h1234, 1'b0, 6, a1);
        @(posedge i_clk);
        #1;
        chk("w_first_wvalid_dropped", o_wvalid, 0);
        chk("w_first_awvalid_held", o_awvalid, 1);
        chk("w_first_no_bready", o_bready, 0);
        wait_idle();

        // Back-to-back: second request waits through the busy period, accepted in done cycle.
        aw_dly = 0; bresp_cfg = 2'b10; rdata_cfg = 64'h55; rresp_cfg = 2'b01;
        issue(1'b1, 32'h40, 64'hAAAA5555_AAAA5555, 64'h1234, 1'b1, 3, a1);
        issue(1'b0, 32'h48, 64'h0, 64'h55, 1'b0, 3, a2);
        chk("b2b_accept_in_done_cycle", a2, a1 + 3);
        wait_idle();

        // Stray B/R valids while idle must be ignored.
        rdata_cfg = 64'hBAD; rresp_cfg = 2'b10;
        @(negedge i_clk);
        stray = 1'b1;
        repeat (3) begin
            @(negedge i_clk);
            chk("stray_no_rready", o_rready, 0);
            chk("stray_no_bready", o_bready, 0);
        end
        stray = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        chk("stray_rd_data_kept", o_rf_rd_data, 64'h55);
        chk("stray_error_kept", o_rf_error, 0);

        // Reset while waiting for read data: abandoned, no completion afterwards.
        r_dly = 20; rdata_cfg = 64'h77; rresp_cfg = 2'b00;
        issue(1'b0, 32'h60, 64'h0, 64'h77, 1'b0, 21, a3);
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge i_clk);
            if (o_rready) seen = 1;
        end
        chk("rready_reached", seen, 1);
        #2 i_rst = 1'b0;
        #1;
        chk("midrst_rready", o_rready, 0);
        chk("midrst_arvalid", o_arvalid, 0);
        chk("midrst_done", o_rf_done, 0);
        chk("midrst_rd_data", o_rf_rd_data, 0);
        chk("midrst_error", o_rf_error, 0);
        exp_q.delete();
        exp_ar_q.delete();
        @(posedge i_clk);
        #1 i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("ready_after_midrst", o_rf_ready, 1);
        r_dly = 0;
        repeat (25) @(posedge i_clk);
        #1;

        // Read with one wait state on both AR and R after the reset.
        ar_dly = 1; r_dly = 1; rdata_cfg = 64'hFEDCBA98_76543210; rresp_cfg = 2'b00;
        issue(1'b0, 32'h70, 64'h0, 64'hFEDCBA98_76543210, 1'b0, 5, a1);
        wait_idle();
        repeat (3) @(posedge i_clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "timeout");
    end
endmodule
